// File: rtl/multi_cycle_adder.sv
// multi_cycle_adder: word-serial add/subtract unit with an optional halving step.
// Operands are processed CHUNK bits per clock with a registered carry, so
// N = ceil(WIDTH/CHUNK) RUN cycles are followed by one DONE cycle.
// Optional feature macro: MULTI_CYCLE_ADDER_SHIFT_EN. When it is defined, the
// shift input is latched and the result is halved in DONE. When it is not
// defined, the shift input is ignored.
// Note: resetn is active-high despite its name.
module multi_cycle_adder #(
  parameter int unsigned WIDTH = 1028,
  parameter int unsigned CHUNK = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic             shift,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             done,
  output logic             busy
);

  localparam int unsigned N   = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int unsigned TOT = N * CHUNK;
  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [TOT-1:0]  a_q;       // remaining A slices; the current slice is in the low bits
  logic [TOT-1:0]  b_q;       // remaining B' slices; the padding becomes ones when subtracting
  logic [TOT-1:0]  acc;       // slice sums, shifted in from the top
  logic            carry;
  logic            sub_q;
  logic [IW-1:0]   idx;
  logic [CHUNK:0]  slice_sum;
  logic [TOT:0]    ext;
  logic [WIDTH:0]  r_c;
  logic [WIDTH:0]  final_c;

  // One slice of the extended add: A slice + B' slice + carry
  always_comb begin
    slice_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK + 1)'(carry);
  end

  // The extended top bit is 0 + (subtract ? 1 : 0) + carry-out; keep the WIDTH+1 result bits
  assign ext = {carry ^ sub_q, acc};
  assign r_c = (WIDTH + 1)'(ext);

`ifdef MULTI_CYCLE_ADDER_SHIFT_EN
  logic shift_q;

  // Optional logical halving of the add/subtract result
  always_comb begin
    final_c = shift_q ? {1'b0, r_c[WIDTH:1]} : r_c;
  end
`else
  logic unused_shift;
  assign unused_shift = shift;

  // No halving in this build
  always_comb begin
    final_c = r_c;
  end
`endif

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      idx    <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
`ifdef MULTI_CYCLE_ADDER_SHIFT_EN
      shift_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= TOT'(in_a);
            b_q   <= subtract ? ~TOT'(in_b) : TOT'(in_b);
            sub_q <= subtract;
            carry <= subtract;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef MULTI_CYCLE_ADDER_SHIFT_EN
            shift_q <= shift;
`endif
          end
        end
        RUN: begin
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          acc   <= TOT'({slice_sum[CHUNK-1:0], acc} >> CHUNK);
          carry <= slice_sum[CHUNK];
          idx   <= idx + IW'(1);
          if (idx == IW'(N - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          result <= final_c;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_adder.sv
// tb_multi_cycle_adder: the bench drives a default instance (1028/64) and a
// non-multiple instance (100/32) with random stimulus plus corner cases. A
// scoreboard queue holds the expected results, and a negedge monitor checks
// result, latency, the done pulse and busy length.
module tb_multi_cycle_adder;

  localparam int unsigned W0 = 1028;
  localparam int unsigned C0 = 64;
  localparam int unsigned N0 = 17;
  localparam int unsigned W1 = 100;
  localparam int unsigned C1 = 32;
  localparam int unsigned N1 = 4;
`ifdef MULTI_CYCLE_ADDER_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  typedef struct {
    logic [W0:0] val;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start0, start1, subtract, shift;
  logic [W0-1:0] in_a, in_b;
  logic [W0:0]   result0;
  logic [W1:0]   result1;
  logic          done0, busy0, done1, busy1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic pd[2];
  int   bc[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_cycle_adder #(.WIDTH(W0), .CHUNK(C0)) u0 (
    .clk(clk), .resetn(resetn), .start(start0), .subtract(subtract), .shift(shift),
    .in_a(in_a), .in_b(in_b), .result(result0), .done(done0), .busy(busy0)
  );

  multi_cycle_adder #(.WIDTH(W1), .CHUNK(C1)) u1 (
    .clk(clk), .resetn(resetn), .start(start1), .subtract(subtract), .shift(shift),
    .in_a(in_a[W1-1:0]), .in_b(in_b[W1-1:0]), .result(result1), .done(done1), .busy(busy1)
  );

  // Reference: plain wide arithmetic mod 2^(w+1), optionally halved
  function automatic logic [W0:0] model(input logic [W0-1:0] a, input logic [W0-1:0] b,
                                        input logic sub, input logic sh, input int w);
    logic [W0+1:0] one, am, bm, x;
    one = (W0 + 2)'(1);
    am  = {2'b0, a} & ((one << w) - one);
    bm  = {2'b0, b} & ((one << w) - one);
    x   = sub ? (am - bm) : (am + bm);
    x   = x & ((one << (w + 1)) - one);
    if (SHIFT_EN && sh) x = x >> 1;
    return (W0 + 1)'(x);
  endfunction

  function automatic logic [W0-1:0] rnd();
    logic [1055:0] v;
    for (int i = 0; i < 33; i++) v[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      2:       return W0'($urandom_range(0, 20));
      default: return W0'(v);
    endcase
  endfunction

  task automatic check(input string name, input logic [W0:0] act, input logic [W0:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h", name,
               act[W0:W0-31], act[127:0], exp[W0:W0-31], exp[127:0]);
    end
  endtask

  task automatic mon(input int which, input logic dn, input logic bz,
                     input logic [W0:0] res, input int n);
    exp_t e;
    int   sz;
    sz = (which == 0) ? q0.size() : q1.size();
    if (dn) begin
      check("done_one_cycle", (W0 + 1)'(pd[which]), '0);
      if (sz == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done dut%0d: done=1, no operation outstanding", which);
      end else begin
        e = (which == 0) ? q0.pop_front() : q1.pop_front();
        check(which == 0 ? "result_dut0" : "result_dut1", res, e.val);
        check("latency", (W0 + 1)'(cyc - e.cyc), (W0 + 1)'(n + 1));
      end
    end else if (sz > 0) begin
      e = (which == 0) ? q0[0] : q1[0];
      if (cyc - e.cyc > n + 4) begin
        n_cmp++;
        n_err++;
        $display("FAIL timeout dut%0d: no done after %0d cycles, want %0d", which, cyc - e.cyc, n + 1);
        if (which == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
    if (bz) begin
      bc[which]++;
    end else begin
      if (bc[which] != 0) check("busy_len", (W0 + 1)'(bc[which]), (W0 + 1)'(n + 1));
      bc[which] = 0;
    end
    pd[which] = dn;
  endtask

  // Monitor: checks reset values, or scoreboard results for both instances
  initial begin
    pd = '{1'b0, 1'b0};
    bc = '{0, 0};
    forever begin
      @(negedge clk);
      if (resetn) begin
        check("rst_result0", result0, '0);
        check("rst_flags0", (W0 + 1)'({done0, busy0}), '0);
        check("rst_result1", (W0 + 1)'(result1), '0);
        check("rst_flags1", (W0 + 1)'({done1, busy1}), '0);
        q0.delete();
        q1.delete();
        pd = '{1'b0, 1'b0};
        bc = '{0, 0};
      end else begin
        mon(0, done0, busy0, result0, N0);
        mon(1, done1, busy1, (W0 + 1)'(result1), N1);
      end
    end
  end

  task automatic set_start(input int which, input logic v);
    if (which == 0) start0 = v; else start1 = v;
  endtask

  task automatic push(input int which);
    exp_t e;
    e.cyc = cyc + 1;
    e.val = model(in_a, in_b, subtract, shift, which == 0 ? W0 : W1);
    if (which == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic drive(input logic [W0-1:0] a, input logic [W0-1:0] b,
                       input logic sub, input logic sh);
    in_a = a; in_b = b; subtract = sub; shift = sh;
  endtask

  task automatic wait_drain(input int which);
    for (int i = 0; i < 60; i++) begin
      if ((which == 0 ? q0.size() : q1.size()) == 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  // One operation; inputs are scrambled after the start cycle
  task automatic issue(input int which, input logic [W0-1:0] a, input logic [W0-1:0] b,
                       input logic sub, input logic sh);
    @(negedge clk);
    drive(a, b, sub, sh);
    set_start(which, 1'b1);
    push(which);
    @(negedge clk);
    set_start(which, 1'b0);
    drive(rnd(), rnd(), ~sub, ~sh);
    wait_drain(which);
  endtask

  // start held high with changing inputs; accepted every n+2 cycles
  task automatic held(input int which, input int n, input int reps);
    for (int k = 0; k < reps * (n + 2); k++) begin
      @(negedge clk);
      drive(rnd(), rnd(), 1'($urandom), 1'($urandom));
      set_start(which, 1'b1);
      if (k % (n + 2) == 0) push(which);
    end
    @(negedge clk);
    set_start(which, 1'b0);
    wait_drain(which);
  endtask

  // Stimulus sequence
  initial begin
    resetn = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;

    issue(0, '1, W0'(1), 1'b0, 1'b0);
    issue(0, W0'(5), W0'(7), 1'b1, 1'b0);
    issue(0, W0'(7), W0'(5), 1'b1, 1'b0);
    issue(0, W0'(3), W0'(5), 1'b0, 1'b1);
    issue(0, W0'(9), W0'(1), 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) issue(0, rnd(), rnd(), 1'($urandom), 1'($urandom));

    // reset in the middle of an add, then a clean operation
    @(negedge clk);
    drive(rnd(), rnd(), 1'b0, 1'b0);
    start0 = 1'b1;
    push(0);
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    #2 resetn = 1'b1;
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    issue(0, W0'(12345), W0'(678), 1'b0, 1'b0);

    // second start while busy is ignored
    @(negedge clk);
    drive(W0'(100), W0'(23), 1'b0, 1'b0);
    start0 = 1'b1;
    push(0);
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    drive(W0'(999), W0'(1), 1'b1, 1'b0);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_drain(0);

    held(0, N0, 3);

    issue(1, W0'({W1{1'b1}}), W0'({W1{1'b1}}), 1'b0, 1'b0);
    issue(1, W0'(5), W0'(7), 1'b1, 1'b0);
    issue(1, W0'(3), W0'(5), 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) issue(1, rnd(), rnd(), 1'($urandom), 1'($urandom));
    held(1, N1, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
